sequenciador_jogo_memoria: RTL and testbench

//  Control unit for the memory-challenge game. Latches the game configuration on a start

---
 rtl/jogo_memoria_pkg.sv | 29 ++
 rtl/temporizador_ciclos.sv | 30 +++
 rtl/sequenciador_jogo_memoria.sv | 155 +++++++++++++++
 tb/tb_sequenciador_jogo_memoria.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_memoria_pkg.sv
// Shared definitions for the memory-game control unit: state codes, config bit
// positions and counter widths.
package jogo_memoria_pkg;

    localparam int unsigned W_ESTADO   = 5;
    localparam int unsigned W_ENDERECO = 4;

    localparam int unsigned CFG_DEMO        = 0;
    localparam int unsigned CFG_SEM_TIMEOUT = 1;

    typedef enum logic [W_ESTADO-1:0] {
        ST_INICIAL       = 5'b00000,
        ST_PREPARA       = 5'b00001,
        ST_INICIO_RODADA = 5'b00010,
        ST_MOSTRA        = 5'b00011,
        ST_INTERVALO     = 5'b00100,
        ST_PROXIMO_LED   = 5'b00101,
        ST_ZERA_END      = 5'b00110,
        ST_ESPERA        = 5'b00111,
        ST_REGISTRA      = 5'b01000,
        ST_COMPARA       = 5'b01001,
        ST_PROX_JOGADA   = 5'b01010,
        ST_PROX_RODADA   = 5'b01011,
        ST_GANHOU        = 5'b01100,
        ST_PERDEU        = 5'b01101,
        ST_TIMEOUT       = 5'b01110
    } estado_t;

endpackage

// File: rtl/temporizador_ciclos.sv
// Cycle timer: counts enabled cycles from zero and flags the M-th one.
// The count parks at M-1 instead of wrapping, so fim stays high while enabled.
module temporizador_ciclos #(
    parameter int unsigned M = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable && (contagem != ULTIMO)) begin
            contagem <= contagem + W'(1);
        end
    end

    assign fim = enable && (contagem == ULTIMO);

endmodule

// File: rtl/sequenciador_jogo_memoria.sv
// Control unit of the memory game: replays the stored sequence each round, then
// collects and checks the player's moves, ending in win, loss or timeout.
module sequenciador_jogo_memoria
    import jogo_memoria_pkg::*;
#(
    parameter int unsigned T_LED     = 500,
    parameter int unsigned T_GAP     = 250,
    parameter int unsigned T_TIMEOUT = 5000,
    parameter int unsigned N_NORMAL  = 16,
    parameter int unsigned N_DEMO    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  jogar,
    input  logic [1:0]            configuracao,
    input  logic                  jogada_feita,
    input  logic                  igual,
    output logic [W_ENDERECO-1:0] endereco,
    output logic [W_ENDERECO-1:0] rodada,
    output logic                  mostra_led,
    output logic                  registra_jogada,
    output logic                  modo,
    output logic                  pronto,
    output logic                  ganhou,
    output logic                  perdeu,
    output logic                  timeout,
    output logic [W_ESTADO-1:0]   estado
);

    estado_t                 estado_atual;
    estado_t                 proximo_estado;
    logic [1:0]              config_reg;
    logic [W_ENDERECO-1:0]   endereco_reg;
    logic [W_ENDERECO-1:0]   rodada_reg;
    logic [W_ENDERECO-1:0]   ultima_rodada;
    logic                    ultima_posicao;
    logic                    fim_led;
    logic                    fim_gap;
    logic                    fim_timeout;

    assign ultima_posicao = (endereco_reg == rodada_reg);
    assign ultima_rodada  = config_reg[CFG_DEMO] ? W_ENDERECO'(N_DEMO - 1)
                                                 : W_ENDERECO'(N_NORMAL - 1);

    // Each timer runs only in its own state and is held clear everywhere else,
    // so every entry into that state starts counting from zero.
    temporizador_ciclos #(.M(T_LED)) u_tempo_led (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado_atual != ST_MOSTRA),
        .enable (estado_atual == ST_MOSTRA),
        .fim    (fim_led)
    );

    temporizador_ciclos #(.M(T_GAP)) u_tempo_intervalo (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado_atual != ST_INTERVALO),
        .enable (estado_atual == ST_INTERVALO),
        .fim    (fim_gap)
    );

    temporizador_ciclos #(.M(T_TIMEOUT)) u_tempo_jogada (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado_atual != ST_ESPERA),
        .enable (estado_atual == ST_ESPERA),
        .fim    (fim_timeout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_atual <= ST_INICIAL;
        end else begin
            estado_atual <= proximo_estado;
        end
    end

    always_comb begin
        proximo_estado = estado_atual;
        case (estado_atual)
            ST_INICIAL:       if (jogar) proximo_estado = ST_PREPARA;
            ST_PREPARA:       proximo_estado = ST_INICIO_RODADA;
            ST_INICIO_RODADA: proximo_estado = ST_MOSTRA;
            ST_MOSTRA:        if (fim_led) proximo_estado = ST_INTERVALO;
            ST_INTERVALO:     if (fim_gap) proximo_estado = ST_PROXIMO_LED;
            ST_PROXIMO_LED:   proximo_estado = ultima_posicao ? ST_ZERA_END : ST_MOSTRA;
            ST_ZERA_END:      proximo_estado = ST_ESPERA;
            ST_ESPERA: begin
                if (jogada_feita) begin
                    proximo_estado = ST_REGISTRA;
                end else if (fim_timeout && !config_reg[CFG_SEM_TIMEOUT]) begin
                    proximo_estado = ST_TIMEOUT;
                end
            end
            ST_REGISTRA:      proximo_estado = ST_COMPARA;
            ST_COMPARA: begin
                if (!igual) begin
                    proximo_estado = ST_PERDEU;
                end else if (ultima_posicao) begin
                    proximo_estado = (rodada_reg == ultima_rodada) ? ST_GANHOU : ST_PROX_RODADA;
                end else begin
                    proximo_estado = ST_PROX_JOGADA;
                end
            end
            ST_PROX_JOGADA:   proximo_estado = ST_ESPERA;
            ST_PROX_RODADA:   proximo_estado = ST_INICIO_RODADA;
            ST_GANHOU, ST_PERDEU, ST_TIMEOUT:
                              if (jogar) proximo_estado = ST_PREPARA;
            default:          proximo_estado = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            config_reg   <= '0;
            endereco_reg <= '0;
            rodada_reg   <= '0;
        end else begin
            case (estado_atual)
                ST_PREPARA: begin
                    config_reg <= configuracao;
                    rodada_reg <= '0;
                end
                ST_INICIO_RODADA, ST_ZERA_END: endereco_reg <= '0;
                ST_PROXIMO_LED: if (!ultima_posicao) endereco_reg <= endereco_reg + W_ENDERECO'(1);
                ST_PROX_JOGADA: endereco_reg <= endereco_reg + W_ENDERECO'(1);
                ST_PROX_RODADA: rodada_reg   <= rodada_reg + W_ENDERECO'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        mostra_led      = 1'b0;
        registra_jogada = 1'b0;
        ganhou          = 1'b0;
        perdeu          = 1'b0;
        timeout         = 1'b0;
        case (estado_atual)
            ST_MOSTRA:   mostra_led      = 1'b1;
            ST_REGISTRA: registra_jogada = 1'b1;
            ST_GANHOU:   ganhou          = 1'b1;
            ST_PERDEU:   perdeu          = 1'b1;
            ST_TIMEOUT:  timeout         = 1'b1;
            default: ;
        endcase
        pronto   = ganhou || perdeu || timeout;
        estado   = estado_atual;
        endereco = endereco_reg;
        rodada   = rodada_reg;
        modo     = config_reg[CFG_DEMO];
    end

endmodule

// File: tb/tb_sequenciador_jogo_memoria.sv
// Bench for sequenciador_jogo_memoria: whole games are expanded from the game rules
// into per-cycle {inputs, expected outputs} records, then applied and compared.
module tb_sequenciador_jogo_memoria;

    localparam int T_LED    = 5;
    localparam int T_GAP    = 3;
    localparam int T_TO     = 20;
    localparam int N_NORMAL = 16;
    localparam int N_DEMO   = 4;

    localparam logic [4:0] S_INICIAL       = 5'b00000;
    localparam logic [4:0] S_PREPARA       = 5'b00001;
    localparam logic [4:0] S_INICIO_RODADA = 5'b00010;
    localparam logic [4:0] S_MOSTRA        = 5'b00011;
    localparam logic [4:0] S_INTERVALO     = 5'b00100;
    localparam logic [4:0] S_PROXIMO_LED   = 5'b00101;
    localparam logic [4:0] S_ZERA_END      = 5'b00110;
    localparam logic [4:0] S_ESPERA        = 5'b00111;
    localparam logic [4:0] S_REGISTRA      = 5'b01000;
    localparam logic [4:0] S_COMPARA       = 5'b01001;
    localparam logic [4:0] S_PROX_JOGADA   = 5'b01010;
    localparam logic [4:0] S_PROX_RODADA   = 5'b01011;
    localparam logic [4:0] S_GANHOU        = 5'b01100;
    localparam logic [4:0] S_PERDEU        = 5'b01101;
    localparam logic [4:0] S_TIMEOUT       = 5'b01110;

    localparam int K_WIN      = 0;
    localparam int K_WRONG    = 1;
    localparam int K_TIMEOUT  = 2;
    localparam int K_LONGWAIT = 3;

    typedef struct {
        logic       jogar;
        logic [1:0] cfg;
        logic       jf;
        logic       ig;
        logic [4:0] est;
        logic [3:0] e;
        logic [3:0] r;
        logic       modo;
    } cyc_t;

    typedef struct {
        string      name;
        logic [1:0] cfg;
        int         kind;
        int         fr;
        int         fi;
    } script_t;

    logic       clock;
    logic       reset;
    logic       jogar;
    logic [1:0] configuracao;
    logic       jogada_feita;
    logic       igual;
    logic [3:0] endereco;
    logic [3:0] rodada;
    logic       mostra_led;
    logic       registra_jogada;
    logic       modo;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [4:0] estado;

    sequenciador_jogo_memoria #(
        .T_LED     (T_LED),
        .T_GAP     (T_GAP),
        .T_TIMEOUT (T_TO),
        .N_NORMAL  (N_NORMAL),
        .N_DEMO    (N_DEMO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .jogar           (jogar),
        .configuracao    (configuracao),
        .jogada_feita    (jogada_feita),
        .igual           (igual),
        .endereco        (endereco),
        .rodada          (rodada),
        .mostra_led      (mostra_led),
        .registra_jogada (registra_jogada),
        .modo            (modo),
        .pronto          (pronto),
        .ganhou          (ganhou),
        .perdeu          (perdeu),
        .timeout         (timeout),
        .estado          (estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    cyc_t       q[$];
    logic [4:0] m_est;
    logic [3:0] m_end;
    logic [3:0] m_rod;
    logic       m_modo;
    logic       m_sem;
    logic [1:0] g_cfg;

    task automatic check(input string name, input logic [4:0] est, input logic [3:0] e,
                         input logic [3:0] r, input logic m, output bit ok);
        logic [19:0] act;
        logic [19:0] expv;
        logic        fin;
        fin  = (est == S_GANHOU) || (est == S_PERDEU) || (est == S_TIMEOUT);
        act  = {estado, endereco, rodada, mostra_led, registra_jogada, modo,
                pronto, ganhou, perdeu, timeout};
        expv = {est, e, r, est == S_MOSTRA, est == S_REGISTRA, m,
                fin, est == S_GANHOU, est == S_PERDEU, est == S_TIMEOUT};
        checks++;
        ok = (act === expv);
        if (!ok) begin
            errors++;
            $display("FAIL %s: {estado,end,rod,led,reg,modo,pronto,g,p,t} got=%05h expected=%05h",
                     name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_est  = S_INICIAL;
        m_end  = '0;
        m_rod  = '0;
        m_modo = 1'b0;
        m_sem  = 1'b0;
    endtask

    // Called 2 time units after a rising edge, so the check lands between edges.
    task automatic assert_reset(input string name);
        bit ok;
        reset = 1'b0;
        jogar = 1'b0; configuracao = '0; jogada_feita = 1'b0; igual = 1'b0;
        #1 check({name, "_async"}, S_INICIAL, '0, '0, 1'b0, ok);
        @(negedge clock);
        check({name, "_hold"}, S_INICIAL, '0, '0, 1'b0, ok);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic reset_dut(input string name);
        @(posedge clock);
        #2;
        assert_reset(name);
    endtask

    // Appends n cycles in state est; inputs the state ignores are randomised.
    task automatic emit(input logic [4:0] est, input int n, input logic jg,
                        input logic jf, input logic ig);
        for (int k = 0; k < n; k++) begin
            cyc_t c;
            c.est   = est;
            c.e     = m_end;
            c.r     = m_rod;
            c.modo  = m_modo;
            c.jogar = 1'($urandom_range(0, 1));
            c.cfg   = 2'($urandom_range(0, 3));
            c.jf    = 1'($urandom_range(0, 1));
            c.ig    = 1'($urandom_range(0, 1));
            if (est == S_INICIAL || est == S_GANHOU || est == S_PERDEU || est == S_TIMEOUT)
                c.jogar = jg;
            if (est == S_PREPARA) c.cfg = g_cfg;
            if (est == S_ESPERA)  c.jf  = jf;
            if (est == S_COMPARA) c.ig  = ig;
            q.push_back(c);
        end
    endtask

    function automatic int pick_wait();
        if (m_sem) return int'($urandom_range(0, 2 * T_TO));
        if ($urandom_range(0, 3) == 0) return T_TO - 1;
        return int'($urandom_range(0, T_TO - 1));
    endfunction

    // Expands one game, from the current idle/final state to its final state.
    task automatic play_game(input logic [1:0] cfg, input int kind, input int fr, input int fi);
        int lim;
        int w;
        bit done;
        g_cfg = cfg;
        emit(m_est, int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b0);
        emit(m_est, 1, 1'b1, 1'b0, 1'b0);
        emit(S_PREPARA, 1, 1'b0, 1'b0, 1'b0);
        m_modo = cfg[0];
        m_sem  = cfg[1];
        m_rod  = '0;
        lim    = m_modo ? N_DEMO : N_NORMAL;
        done   = 1'b0;
        for (int r = 0; r < lim && !done; r++) begin
            emit(S_INICIO_RODADA, 1, 1'b0, 1'b0, 1'b0);
            m_end = '0;
            for (int i = 0; i <= r; i++) begin
                emit(S_MOSTRA, T_LED, 1'b0, 1'b0, 1'b0);
                emit(S_INTERVALO, T_GAP, 1'b0, 1'b0, 1'b0);
                emit(S_PROXIMO_LED, 1, 1'b0, 1'b0, 1'b0);
                if (i < r) m_end = 4'(i + 1);
            end
            emit(S_ZERA_END, 1, 1'b0, 1'b0, 1'b0);
            m_end = '0;
            for (int j = 0; j <= r && !done; j++) begin
                bit hit;
                hit = (r == fr) && (j == fi);
                if (hit && kind == K_TIMEOUT && !m_sem) begin
                    emit(S_ESPERA, T_TO, 1'b0, 1'b0, 1'b0);
                    m_est = S_TIMEOUT;
                    done  = 1'b1;
                end else begin
                    w = (hit && m_sem && kind != K_WRONG) ? 100 : pick_wait();
                    emit(S_ESPERA, w, 1'b0, 1'b0, 1'b0);
                    emit(S_ESPERA, 1, 1'b0, 1'b1, 1'b0);
                    emit(S_REGISTRA, 1, 1'b0, 1'b0, 1'b0);
                    if (hit && kind == K_WRONG) begin
                        emit(S_COMPARA, 1, 1'b0, 1'b0, 1'b0);
                        m_est = S_PERDEU;
                        done  = 1'b1;
                    end else begin
                        emit(S_COMPARA, 1, 1'b0, 1'b0, 1'b1);
                        if (j == r) begin
                            if (r == lim - 1) begin
                                m_est = S_GANHOU;
                                done  = 1'b1;
                            end else begin
                                emit(S_PROX_RODADA, 1, 1'b0, 1'b0, 1'b0);
                                m_rod = 4'(r + 1);
                            end
                        end else begin
                            emit(S_PROX_JOGADA, 1, 1'b0, 1'b0, 1'b0);
                            m_end = 4'(j + 1);
                        end
                    end
                end
            end
        end
        emit(m_est, int'($urandom_range(1, 3)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_queue(input string tag, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clock);
            check($sformatf("%s[%0d]", tag, i), q[i].est, q[i].e, q[i].r, q[i].modo, ok);
            if (!ok) break;
            jogar        = q[i].jogar;
            configuracao = q[i].cfg;
            jogada_feita = q[i].jf;
            igual        = q[i].ig;
        end
    endtask

    task automatic run_game(input string tag, input logic [1:0] cfg, input int kind,
                            input int fr, input int fi);
        bit ok;
        q.delete();
        play_game(cfg, kind, fr, fi);
        run_queue(tag, ok);
        if (!ok) reset_dut({tag, "_recover"});
    endtask

    script_t scripts[7];

    initial begin
        bit ok;
        int idx;

        scripts[0] = '{"demo_win",          2'b01, K_WIN,      0, 0};
        scripts[1] = '{"demo_wrong_r0",     2'b01, K_WRONG,    0, 0};
        scripts[2] = '{"demo_timeout_r0",   2'b01, K_TIMEOUT,  0, 0};
        scripts[3] = '{"demo_no_timeout",   2'b11, K_LONGWAIT, 0, 0};
        scripts[4] = '{"normal_wrong_r2",   2'b10, K_WRONG,    2, 1};
        scripts[5] = '{"normal_timeout_r1", 2'b00, K_TIMEOUT,  1, 1};
        scripts[6] = '{"normal_win",        2'b00, K_WIN,      0, 0};

        reset = 1'b0;
        jogar = 1'b0; configuracao = '0; jogada_feita = 1'b0; igual = 1'b0;
        model_reset();
        reset_dut("power_on");

        for (int s = 0; s < 7; s++)
            run_game(scripts[s].name, scripts[s].cfg, scripts[s].kind,
                     scripts[s].fr, scripts[s].fi);

        for (int g = 0; g < 8; g++) begin
            logic [1:0] cfg;
            int kind;
            int lim;
            int fr;
            cfg  = 2'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 3));
            lim  = cfg[0] ? N_DEMO : N_NORMAL;
            if (!cfg[0] && kind != K_WRONG && kind != K_TIMEOUT) kind = K_WRONG;
            fr = cfg[0] ? int'($urandom_range(0, lim - 1)) : int'($urandom_range(0, 5));
            run_game($sformatf("rand%0d", g), cfg, kind, fr, int'($urandom_range(0, fr)));
        end

        // Reset asserted while the third round is replaying its first LED.
        q.delete();
        play_game(2'b01, K_WIN, 0, 0);
        idx = 0;
        while (!(q[idx].est == S_MOSTRA && q[idx].r == 4'd2)) idx++;
        while (q.size() > idx + 1) q.delete(q.size() - 1);
        run_queue("mid_reset_game", ok);
        if (ok) begin
            @(posedge clock);
            #1 check("pre_reset_mostra", S_MOSTRA, 4'd0, 4'd2, 1'b1, ok);
            #1 assert_reset("mid_reset");
        end else begin
            reset_dut("mid_reset_recover");
        end

        run_game("after_reset", 2'b01, K_WRONG, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
